phy_urx: RTL and testbench
==========================

Name: phy_urx

Overview:
- UART receiver; counterpart of the existing microsecond-tick UART transmitter in commu_top.
- Oversamples the serial line using the shared 1 us pulse (pluse_us) on clk_sys.
- Recovers 11-slot frames: start, 8 data LSB-first, 1 check slot, stop.
- Delivers bytes to the command parser as a one-cycle valid strobe with error flags.

Parameters:
- BIT_PERIOD_X100, 868, bit period in hundredths of a microsecond (868 = 115200 baud).
- CNT_W, 8, width of the in-frame microsecond counter; must hold 11*bit period.

Ports:
- clk_sys  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- pluse_us  input  1  one-clk_sys-cycle pulse every 1 us.
- uart_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last received byte; held until next good frame.
- rx_vld  output  1  one-cycle pulse: rx_data updated this cycle.
- rx_ferr  output  1  one-cycle pulse: stop slot sampled low (framing error).
- rx_perr  output  1  one-cycle pulse: check-slot mismatch (only with macro; else constant 0).
- rx_busy  output  1  high from start detect until frame end.

Behaviour:
- Reset values: rx_data=8'h00, rx_vld=0, rx_ferr=0, rx_perr=0, rx_busy=0, synchronizer flops=1, state=IDLE, cnt_us=0.
- Synchronizer: 2-flop on uart_rx. All logic uses the synchronized value rx_s and its previous value.
- cnt_us:
  - Cleared to 0 on start detect.
  - Increments by 1 on each pluse_us while not IDLE/WAIT_HI.
  - Saturates at all-ones.
- Sample points: slot k (k=0..10) is sampled on the pluse_us cycle in which cnt_us becomes S(k)=floor((2k+1)*BIT_PERIOD_X100/200).
  - Default values: 4,13,21,30,39,47,56,65,73,82,91.
  - S(k) is computed at elaboration from the parameter; no run-time multiply.
- State machine:
  - IDLE: a falling edge on rx_s (1->0) moves to START, clears cnt_us, and sets rx_busy=1.
  - START: at S(0), if rx_s=1 the start is false: go to IDLE, busy=0, no flags. If rx_s=0, go to DATA.
  - DATA: at S(1)..S(8), shift rx_s into bit 0..7 of an internal shift register (LSB first). After S(8), go to CHK.
  - CHK: at S(9), capture rx_s as chk_bit, then go to STOP.
  - STOP, sample at S(10):
    - rx_s=1: the next cycle gives rx_data<=shift register and rx_vld=1, then IDLE.
    - rx_s=0: the next cycle gives rx_ferr=1, rx_data unchanged, no rx_vld, then WAIT_HI.
    - rx_busy drops in the same cycle as the vld/ferr pulse.
  - WAIT_HI: stays until rx_s=1 (line break tolerated), then IDLE. rx_busy=0 in this state.
- Latency: rx_vld rises 1 clk_sys cycle after the S(10) sample, plus 2-cycle synchronizer delay relative to the line.
- Back-to-back frames: the return to IDLE happens at mid-stop, so a start edge arriving 0.5 bit after S(10) is caught. No idle gap is required beyond the stop half-bit.
- pluse_us and uart_rx edges in the same cycle: edge detect takes priority. Counting starts from the next pluse_us.
- Reset mid-frame: immediately aborts to IDLE with outputs at reset values. No pulse is emitted for the partial frame.
- rx_vld, rx_ferr and rx_perr are mutually exclusive per frame, except as stated under the macro.

Optional Feature:
- Macro: PHY_URX_PARITY_CHECK_EN.
- Defined:
  - At the STOP evaluation, if chk_bit != ^shift register (even XOR, matching the transmitter's xor_tx), rx_perr pulses in the same cycle rx_vld would.
  - rx_vld is suppressed and rx_data is not updated.
  - A framing error takes priority: only rx_ferr pulses.
- Undefined:
  - chk_bit is ignored (the transmitter sends 1 in that slot).
  - rx_perr is tied 0.

Test Plan:
- Idle line, 8'hA5 sent at 8.68 us/bit → one rx_vld pulse, rx_data=8'hA5, rx_ferr=rx_perr=0, rx_busy high about 91 us.
- Alternating 8'h55/8'hAA frames back-to-back, stop slot only 1 bit → every byte received in order, no ferr, no missed start.
- Low glitch of 2 us on idle line → START aborts at S(0), no pulses, rx_busy back to 0, next frame 8'h3C received correctly.
- Frame 8'hFF with stop slot held low for 30 us → rx_ferr pulse once, rx_data keeps previous value, no rx_vld until line high; following frame 8'h01 received.
- rst asserted at cnt_us=40 mid-frame, released 5 us later, then frame 8'h81 → outputs at reset values during rst, no pulse for the aborted frame, 8'h81 received.
- Macro defined: 8'h07 with check slot 1 → rx_vld, rx_data=8'h07. 8'h07 with check slot 0 → rx_perr only, rx_data unchanged.

Source files
------------

// File: rtl/phy_urx.sv
// phy_urx: UART receiver, 11-slot frames sampled on the 1 us tick; check-slot parity under PHY_URX_PARITY_CHECK_EN.
// Latency: result pulse one clk_sys after the stop-slot sample (+2 sync); no backpressure, pulses are never held.
module phy_urx #(
  parameter int BIT_PERIOD_X100 = 868,
  parameter int CNT_W           = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pluse_us,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_ferr,
  output logic       rx_perr,
  output logic       rx_busy
);

  function automatic logic [CNT_W-1:0] s_pt(input int k);
    return CNT_W'(((2 * k + 1) * BIT_PERIOD_X100) / 200);
  endfunction

  // Sample point of slot k, in microseconds after start detect; entries past slot 10 are never reached.
  localparam logic [CNT_W-1:0] SP [0:15] = '{
    s_pt(0), s_pt(1), s_pt(2), s_pt(3), s_pt(4), s_pt(5), s_pt(6), s_pt(7),
    s_pt(8), s_pt(9), s_pt(10), '1, '1, '1, '1, '1
  };

  typedef enum logic [2:0] {IDLE, START, DATA, CHK, STOP, WAIT_HI} state_t;

  state_t           state;
  logic             rx_m, rx_s, rx_d;
  logic [CNT_W-1:0] cnt_us;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       slot;
  logic [7:0]       shreg;
  logic             hit;
  logic             fall;
`ifdef PHY_URX_PARITY_CHECK_EN
  logic             chk_bit;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall    = rx_d & ~rx_s;
  assign cnt_inc = (cnt_us == '1) ? cnt_us : cnt_us + CNT_W'(1);
  // A slot is sampled on the tick that moves the counter onto its sample point.
  assign hit     = pluse_us && (cnt_inc == SP[slot]);

`ifndef PHY_URX_PARITY_CHECK_EN
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt_us  <= '0;
      slot    <= 4'd0;
      shreg   <= 8'h00;
      rx_data <= 8'h00;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      rx_busy <= 1'b0;
`ifdef PHY_URX_PARITY_CHECK_EN
      rx_perr <= 1'b0;
      chk_bit <= 1'b0;
`endif
    end else begin
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
`ifdef PHY_URX_PARITY_CHECK_EN
      rx_perr <= 1'b0;
`endif
      if (pluse_us && state != IDLE && state != WAIT_HI)
        cnt_us <= cnt_inc;

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            cnt_us  <= '0;
            slot    <= 4'd0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (hit) begin
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
              slot  <= 4'd1;
            end
          end
        end
        DATA: begin
          if (hit) begin
            shreg <= {rx_s, shreg[7:1]};
            slot  <= slot + 4'd1;
            if (slot == 4'd8)
              state <= CHK;
          end
        end
        CHK: begin
          if (hit) begin
`ifdef PHY_URX_PARITY_CHECK_EN
            chk_bit <= rx_s;
`endif
            slot  <= slot + 4'd1;
            state <= STOP;
          end
        end
        STOP: begin
          if (hit) begin
            rx_busy <= 1'b0;
            if (!rx_s) begin
              rx_ferr <= 1'b1;
              state   <= WAIT_HI;
            end else begin
              state <= IDLE;
`ifdef PHY_URX_PARITY_CHECK_EN
              if (chk_bit != ^shreg) begin
                rx_perr <= 1'b1;
              end else begin
                rx_vld  <= 1'b1;
                rx_data <= shreg;
              end
`else
              rx_vld  <= 1'b1;
              rx_data <= shreg;
`endif
            end
          end
        end
        WAIT_HI: begin
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_urx.sv
// Bench for phy_urx: drives timed serial frames, predicts per-frame outcome, checks pulses, data and busy timing.
`timescale 1ns/1ps
module tb_phy_urx;

  localparam int BIT_NS = 8680;
`ifdef PHY_URX_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam logic [2:0] K_VLD  = 3'b100;
  localparam logic [2:0] K_FERR = 3'b010;
  localparam logic [2:0] K_PERR = 3'b001;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pluse_us;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_vld, rx_ferr, rx_perr, rx_busy;

  phy_urx dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .pluse_us(pluse_us),
    .uart_rx (uart_rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_ferr (rx_ferr),
    .rx_perr (rx_perr),
    .rx_busy (rx_busy)
  );

  always #50 clk_sys = ~clk_sys;

  initial begin
    pluse_us = 1'b0;
    forever begin
      repeat (9) @(posedge clk_sys);
      #1 pluse_us = 1'b1;
      @(posedge clk_sys);
      #1 pluse_us = 1'b0;
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] last_good = 8'h00;

  // Frame-level outcome: broken stop wins, then check-slot parity (if enabled), else the byte is delivered.
  task automatic push_exp(input logic [7:0] b, input logic chk, input bit stop_low);
    ev_t e;
    if (stop_low) begin
      e.kind = K_FERR;
      e.data = last_good;
    end else if (PAR && (chk != ^b)) begin
      e.kind = K_PERR;
      e.data = last_good;
    end else begin
      e.kind    = K_VLD;
      e.data    = b;
      last_good = b;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic chk, input int stop_low_ns, input int gap_ns);
    push_exp(b, chk, stop_low_ns > 0);
    uart_rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      #BIT_NS;
    end
    uart_rx = chk;
    #BIT_NS;
    if (stop_low_ns > 0) begin
      uart_rx = 1'b0;
      #(stop_low_ns);
    end
    uart_rx = 1'b1;
    #BIT_NS;
    if (gap_ns > 0)
      #(gap_ns);
  endtask

  ev_t  mon_e;
  logic busy_prev = 1'b0;
  time  busy_rise = 0;
  time  dur;

  always @(negedge clk_sys) begin
    if (!rst) begin
      if (rx_busy && !busy_prev)
        busy_rise = $time;
      if (rx_vld || rx_ferr || rx_perr) begin
        if (exp_q.size() == 0) begin
          expect_eq("unexpected_evt", {29'd0, rx_vld, rx_ferr, rx_perr}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          expect_eq("evt_kind", {29'd0, rx_vld, rx_ferr, rx_perr}, {29'd0, mon_e.kind});
          expect_eq("evt_data", {24'd0, rx_data}, {24'd0, mon_e.data});
          expect_eq("busy_at_end", {31'd0, rx_busy}, 32'd0);
          dur = $time - busy_rise;
          expect_eq("busy_dur_91us", {31'd0, (dur >= 89000 && dur <= 93000)}, 32'd1);
        end
      end
    end
    busy_prev = rx_busy;
  end

  task automatic check_reset_outputs(input string phase);
    @(negedge clk_sys);
    expect_eq({phase, "_data"}, {24'd0, rx_data}, 32'd0);
    expect_eq({phase, "_vld"},  {31'd0, rx_vld},  32'd0);
    expect_eq({phase, "_ferr"}, {31'd0, rx_ferr}, 32'd0);
    expect_eq({phase, "_perr"}, {31'd0, rx_perr}, 32'd0);
    expect_eq({phase, "_busy"}, {31'd0, rx_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       c;
    int         sl, gap;
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    #20013;

    send_frame(8'hA5, 1'b1, 0, 20000);

    for (int i = 0; i < 6; i++)
      send_frame(i[0] ? 8'hAA : 8'h55, 1'b1, 0, 0);
    #20000;

    // 2 us low glitch on an idle line
    uart_rx = 1'b0;
    #2000;
    uart_rx = 1'b1;
    #20000;
    @(negedge clk_sys);
    expect_eq("glitch_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, 0, 20000);

    send_frame(8'hFF, 1'b1, 30000, BIT_NS);
    send_frame(8'h01, 1'b1, 0, 20000);

    // Reset about 40 us into a frame, line released high during reset
    b = 8'hC3;
    uart_rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 3; i++) begin
      uart_rx = b[i];
      #BIT_NS;
    end
    uart_rx = b[3];
    #5580;
    expect_eq("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    rst     = 1'b1;
    uart_rx = 1'b1;
    last_good = 8'h00;
    check_reset_outputs("rst_mid");
    #5000;
    rst = 1'b0;
    #20000;
    send_frame(8'h81, 1'b1, 0, 20000);

    send_frame(8'h07, 1'b1, 0, 20000);
    send_frame(8'h07, 1'b0, 0, 20000);

    for (int n = 0; n < 25; n++) begin
      b   = 8'($urandom);
      c   = 1'($urandom);
      sl  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(30000, 9000)) : 0;
      gap = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(20000, 0));
      if (sl > 0 && gap < BIT_NS)
        gap = BIT_NS;
      send_frame(b, c, sl, gap);
    end

    #30000;
    @(negedge clk_sys);
    expect_eq("missing_evts", exp_q.size(), 32'd0);
    expect_eq("final_busy", {31'd0, rx_busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
